// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants and divider FSM state type
package mips_pkg;

    localparam int STAGE_PC  = 0;
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;
    localparam int STAGE_WB  = 5;

    localparam int NUM_STAGES         = STAGE_WB;
    localparam int DIV_CYCLES_DEFAULT = 32;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_e;

endpackage

// File: rtl/div_occupancy_counter.sv
// rtl/div_occupancy_counter.sv - divider occupancy FSM with down-counter, busy/done flags and abort
module div_occupancy_counter
    import mips_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
    parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic abort,
    output logic div_busy,
    output logic div_done
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (abort) begin
            state_d = DIV_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        state_d = DIV_BUSY;
                        count_d = CNT_W'(DIV_CYCLES - 1);
                    end
                end
                DIV_BUSY: begin
                    // A start while busy is deliberately ignored: no restart.
                    if (count_q == '0) begin
                        state_d = DIV_IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = DIV_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        div_busy = (state_q == DIV_BUSY);
        div_done = (state_q == DIV_BUSY) && (count_q == '0) && !abort;
    end

endmodule

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - pipeline stall/bubble/flush controller; PIPELINE_CONTROL_PERF_EN adds stall_cycles
module pipeline_control
    import mips_pkg::*;
#(
    parameter int STAGES     = NUM_STAGES,
    parameter int DIV_STAGE  = STAGE_EX,
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
    parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [STAGES-1:0] stall_request,
    input  logic              div_start,
    input  logic              flush_request,
    output logic [STAGES:0]   stall,
    output logic [STAGES-1:0] bubble,
    output logic              flush,
    output logic              div_busy,
    output logic              div_done
`ifdef PIPELINE_CONTROL_PERF_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    logic              div_hold;
    logic              abort;
    logic [STAGES-1:0] req;
    logic [STAGES:0]   stall_pre;
    logic              acc;

    assign abort    = flush_request | reset;
    assign div_hold = div_busy & ~div_done;

    div_occupancy_counter #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_occupancy_counter (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .abort    (abort),
        .div_busy (div_busy),
        .div_done (div_done)
    );

    // Suffix-OR from the top: stall[j] is set when any stage k >= j requests.
    always_comb begin
        req       = stall_request;
        stall_pre = '0;
        acc       = 1'b0;
        for (int k = 1; k <= STAGES; k++) begin
            if (k == DIV_STAGE) begin
                req[k-1] = stall_request[k-1] | div_hold;
            end
        end
        for (int j = STAGES; j >= 1; j--) begin
            acc          = acc | req[j-1];
            stall_pre[j] = acc;
        end
        stall_pre[0] = acc;
    end

    always_comb begin
        flush  = flush_request & ~reset;
        stall  = '0;
        bubble = '0;
        if (!reset && !flush_request) begin
            stall = stall_pre;
            for (int j = 1; j <= STAGES; j++) begin
                bubble[j-1] = stall_pre[j-1] & ~stall_pre[j];
            end
        end
    end

`ifdef PIPELINE_CONTROL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Flush does not clear the counter; only reset does.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall != '0) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
